// File: rtl/snail_ram_arb_pkg.sv
// snail_ram_arb_pkg: arbiter state and owner encodings shared by the RAM arbiter
package snail_ram_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WR, ARB_RD, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;
endpackage

// File: rtl/snail_ram_arb.sv
// snail_ram_arb: shares the single data RAM between the SNAIL core and a host port
module snail_ram_arb
  import snail_ram_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdat,
  input  logic          cpu_rd_,
  input  logic          cpu_wr_,
  output logic [DW-1:0] cpu_rdat,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdat,
  output logic          host_gnt,
  output logic          host_done,
  output logic [DW-1:0] host_rdat,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdat,
  output logic          ram_rd_,
  output logic          ram_wr_,
  input  logic [DW-1:0] ram_rdat
);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int WW = $clog2(MAX_WAIT + 2);
  arb_state_t    state, state_nx;
  owner_t        owner, owner_nx;
  logic [LW-1:0] lat_cnt;
  logic [WW-1:0] wait_cnt;
  logic          cpu_req, host_win, last_rd, grant;
  assign cpu_req  = ~cpu_rd_ | ~cpu_wr_;
  assign host_win = host_req & (~cpu_req | (wait_cnt == WW'(MAX_WAIT)));
  assign last_rd  = lat_cnt == LW'(RD_LAT - 1);
  assign grant    = (state == ARB_IDLE) & (host_win | cpu_req);
  // The core commits in DONE, so its stall drops only there
  assign cpu_stall = ~rst_ | (cpu_req & ~(state == ARB_DONE & owner == OWN_CPU));
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      ARB_IDLE: begin
        owner_nx = host_win ? OWN_HOST : cpu_req ? OWN_CPU : owner;
        state_nx = host_win ? (host_we ? ARB_WR : ARB_RD) :
                   cpu_req  ? (~cpu_wr_ ? ARB_WR : ARB_RD) : ARB_IDLE;
      end
      ARB_WR:  state_nx = ARB_DONE;
      ARB_RD:  state_nx = last_rd ? ARB_DONE : ARB_RD;
      default: state_nx = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ARB_IDLE;
      owner     <= OWN_CPU;
      lat_cnt   <= '0;
      wait_cnt  <= '0;
      ram_rd_   <= 1'b1;
      ram_wr_   <= 1'b1;
      ram_addr  <= '0;
      ram_wdat  <= '0;
      cpu_rdat  <= '0;
      host_rdat <= '0;
      host_gnt  <= 1'b0;
      host_done <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      lat_cnt   <= (state == ARB_RD) ? lat_cnt + 1'b1 : '0;
      // Strobes come from the next state so RAM pins are clean register outputs
      ram_wr_   <= state_nx != ARB_WR;
      ram_rd_   <= state_nx != ARB_RD;
      host_gnt  <= (state_nx != ARB_IDLE) && (owner_nx == OWN_HOST);
      host_done <= (state_nx == ARB_DONE) && (owner_nx == OWN_HOST);
      wait_cnt  <= (!host_req || (state == ARB_IDLE && host_win)) ? '0 :
                   (grant && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      if (grant) begin
        ram_addr <= host_win ? host_addr : cpu_addr;
        ram_wdat <= host_win ? host_wdat : cpu_wdat;
      end
      if (state == ARB_RD && last_rd && owner == OWN_CPU) cpu_rdat <= ram_rdat;
      if (state == ARB_RD && last_rd && owner == OWN_HOST) host_rdat <= ram_rdat;
    end
  end
endmodule
